scope_trace_renderer: RTL and testbench



---
 rtl/scope_pkg.sv | 34 +++
 rtl/scope_trace_renderer_if.sv | 31 +++
 rtl/scope_vga_timing.sv | 51 +++++
 rtl/scope_trace_renderer.sv | 224 ++++++++++++++++++++++
 tb/tb_scope_trace_renderer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scope_pkg.sv
// Shared types and constants for the oscilloscope trace renderer.
//   cap_state_t  : capture FSM states
//   chan_colour  : per-channel {R,G,B} on/off mask (ch0 yellow, ch1 cyan,
//                  ch2 magenta, ch3 green)
//   *_DEF        : 1280x1024@60 timing defaults (108 MHz pixel clock)
package scope_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } cap_state_t;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int H_FRONT_DEF  = 48;
  localparam int H_SYNC_DEF   = 112;
  localparam int H_BACK_DEF   = 248;
  localparam int V_ACTIVE_DEF = 1024;
  localparam int V_FRONT_DEF  = 1;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BACK_DEF   = 38;

  // Each bit expands to a full-scale colour component in the renderer.
  function automatic logic [2:0] chan_colour(input int ch);
    case (ch)
      0:       return 3'b110;
      1:       return 3'b011;
      2:       return 3'b101;
      default: return 3'b010;
    endcase
  endfunction

endpackage

// File: rtl/scope_trace_renderer_if.sv
// Sample-in / video-out bundle of the trace renderer.
//   sample_valid, sample_data, trig_level : ADC side into the renderer
//   vga_hsync, vga_vsync, R, G, B         : VGA DAC pins
//   capture_busy, trig_auto               : capture status
// master = sample source / display sink, slave = renderer.
interface scope_trace_renderer_if #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 10,
  parameter int COLOUR_W = 8
);
  logic                         sample_valid;
  logic [CHANNELS*SAMPLE_W-1:0] sample_data;
  logic [SAMPLE_W-1:0]          trig_level;
  logic                         vga_hsync;
  logic                         vga_vsync;
  logic [COLOUR_W-1:0]          R;
  logic [COLOUR_W-1:0]          G;
  logic [COLOUR_W-1:0]          B;
  logic                         capture_busy;
  logic                         trig_auto;

  modport master (
    output sample_valid, sample_data, trig_level,
    input  vga_hsync, vga_vsync, R, G, B, capture_busy, trig_auto
  );

  modport slave (
    input  sample_valid, sample_data, trig_level,
    output vga_hsync, vga_vsync, R, G, B, capture_busy, trig_auto
  );
endinterface

// File: rtl/scope_vga_timing.sv
// VGA raster generator.
//   clock, reset  : pixel clock, async active-high reset
//   h_count       : 0..H_TOTAL-1, v_count : 0..V_TOTAL-1
//   hsync_raw     : high in the horizontal sync window (undelayed)
//   vsync_raw     : high in the vertical sync window (undelayed)
//   active        : inside the visible area
//   vblank_start  : first pixel of the first blank line
module scope_vga_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FRONT  = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BACK   = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FRONT  = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 38,
  localparam int HW = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK),
  localparam int VW = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [HW-1:0] h_count,
  output logic [VW-1:0] v_count,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          active,
  output logic          vblank_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == HW'(H_TOTAL - 1)) begin
      h_count <= '0;
      v_count <= (v_count == VW'(V_TOTAL - 1)) ? '0 : v_count + VW'(1);
    end else begin
      h_count <= h_count + HW'(1);
    end
  end

  assign hsync_raw    = (h_count >= HW'(H_ACTIVE + H_FRONT)) &&
                        (h_count <  HW'(H_ACTIVE + H_FRONT + H_SYNC));
  assign vsync_raw    = (v_count >= VW'(V_ACTIVE + V_FRONT)) &&
                        (v_count <  VW'(V_ACTIVE + V_FRONT + V_SYNC));
  assign active       = (h_count < HW'(H_ACTIVE)) && (v_count < VW'(V_ACTIVE));
  assign vblank_start = (v_count == VW'(V_ACTIVE)) && (h_count == '0);

endmodule

// File: rtl/scope_trace_renderer.sv
// N-channel oscilloscope display engine: VGA raster, triggered capture of one
// screen width per channel, and a 2-cycle pixel pipeline drawing each channel
// as a coloured trace on black.
//   clock, reset : pixel clock, async active-high reset
//   bus (slave)  : samples/trigger level in, VGA syncs + RGB and status out
// Build option GRID_OVERLAY_EN: mid-grey graticule every 128 pixels/lines
// behind the traces. Without it the background is pure black.
//
// Capture FSM
//   state   | meaning
//   IDLE    | after reset, waits for a vblank start
//   ARMED   | watching ch0 for a rising crossing of trig_level (or auto)
//   CAPTURE | storing one sample word per valid, addresses 1..H_ACTIVE-1
//   HOLD    | buffer complete, re-arms at the next vblank start
module scope_trace_renderer
  import scope_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int SAMPLE_W    = 10,
  parameter int COLOUR_W    = 8,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FRONT     = H_FRONT_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BACK      = H_BACK_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FRONT     = V_FRONT_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BACK      = V_BACK_DEF,
  parameter int Y_SHIFT     = 0,
  parameter int AUTO_FRAMES = 4
) (
  input logic                    clock,
  input logic                    reset,
  scope_trace_renderer_if.slave  bus
);
  localparam int HW = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam int VW = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
  localparam int AW = $clog2(H_ACTIVE);
  localparam int DW = CHANNELS * SAMPLE_W;
  localparam int FW = (AUTO_FRAMES > 0) ? $clog2(AUTO_FRAMES + 1) : 1;

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          hsync_raw, vsync_raw, active, vblank_start;

  scope_vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clock        (clock),
    .reset        (reset),
    .h_count      (h_count),
    .v_count      (v_count),
    .hsync_raw    (hsync_raw),
    .vsync_raw    (vsync_raw),
    .active       (active),
    .vblank_start (vblank_start)
  );

  // ---------------- capture FSM ----------------
  cap_state_t          state;
  logic [SAMPLE_W-1:0] prev0;
  logic                prev0_ok;
  logic [AW-1:0]       wr_addr;
  logic [FW-1:0]       frame_cnt;
  logic                busy_q, auto_q;

  logic [SAMPLE_W-1:0] cur0;
  logic                level_hit, auto_due, fire, wr_en;
  logic [AW-1:0]       wr_ptr;

  assign cur0      = bus.sample_data[SAMPLE_W-1:0];
  assign level_hit = prev0_ok && (prev0 < bus.trig_level) && (cur0 >= bus.trig_level);
  assign auto_due  = (AUTO_FRAMES != 0) && (frame_cnt >= FW'(AUTO_FRAMES));
  assign fire      = (state == ARMED) && bus.sample_valid && (level_hit || auto_due);
  assign wr_en     = fire || ((state == CAPTURE) && bus.sample_valid);
  assign wr_ptr    = (state == CAPTURE) ? wr_addr : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prev0     <= '0;
      prev0_ok  <= 1'b0;
      wr_addr   <= '0;
      frame_cnt <= '0;
      busy_q    <= 1'b0;
      auto_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (vblank_start) begin
            state     <= ARMED;
            prev0_ok  <= 1'b0;
            frame_cnt <= '0;
            busy_q    <= 1'b1;
          end
        end
        ARMED: begin
          if (fire) begin
            // A genuine crossing outranks a coinciding auto timeout.
            state     <= CAPTURE;
            wr_addr   <= AW'(1);
            frame_cnt <= '0;
            auto_q    <= ~level_hit;
          end else begin
            if (bus.sample_valid) begin
              prev0    <= cur0;
              prev0_ok <= 1'b1;
            end
            if (vblank_start && (frame_cnt < FW'(AUTO_FRAMES)))
              frame_cnt <= frame_cnt + FW'(1);
          end
        end
        CAPTURE: begin
          if (bus.sample_valid) begin
            wr_addr <= wr_addr + AW'(1);
            if (wr_addr == AW'(H_ACTIVE - 1)) begin
              state  <= HOLD;
              busy_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- sample buffer (not reset) ----------------
  logic [DW-1:0] sample_mem [H_ACTIVE];
  logic [DW-1:0] rd_word;

  always_ff @(posedge clock) begin
    if (wr_en)
      sample_mem[wr_ptr] <= bus.sample_data;
    if (h_count < HW'(H_ACTIVE))
      rd_word <= sample_mem[h_count[AW-1:0]];
  end

  // ---------------- pixel pipeline ----------------
  logic          s1_hs, s1_vs, s1_act;
  logic [VW-1:0] s1_v;
`ifdef GRID_OVERLAY_EN
  logic [HW-1:0] s1_h;
`endif
  logic                hs_q, vs_q;
  logic [COLOUR_W-1:0] r_q, g_q, b_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_act <= 1'b0;
      s1_v   <= '0;
`ifdef GRID_OVERLAY_EN
      s1_h   <= '0;
`endif
    end else begin
      s1_hs  <= hsync_raw;
      s1_vs  <= vsync_raw;
      s1_act <= active;
      s1_v   <= v_count;
`ifdef GRID_OVERLAY_EN
      s1_h   <= h_count;
`endif
    end
  end

  logic [SAMPLE_W-1:0] trace_y;
  logic [2:0]          pix;
  logic                hit;

  // Walk channels high to low so the lowest index overwrites on overlap.
  always_comb begin
    trace_y = '0;
    pix     = 3'b000;
    hit     = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      trace_y = rd_word[k*SAMPLE_W +: SAMPLE_W] >> Y_SHIFT;
      if ((32'(trace_y) < V_ACTIVE) && (32'(s1_v) == V_ACTIVE - 1 - 32'(trace_y))) begin
        pix = chan_colour(k);
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      hs_q <= s1_hs;
      vs_q <= s1_vs;
      if (s1_act && hit) begin
        r_q <= {COLOUR_W{pix[2]}};
        g_q <= {COLOUR_W{pix[1]}};
        b_q <= {COLOUR_W{pix[0]}};
      end
`ifdef GRID_OVERLAY_EN
      else if (s1_act && (((32'(s1_h) & 32'h7F) == 32'd0) || ((32'(s1_v) & 32'h7F) == 32'd0))) begin
        r_q <= {1'b1, {(COLOUR_W-1){1'b0}}};
        g_q <= {1'b1, {(COLOUR_W-1){1'b0}}};
        b_q <= {1'b1, {(COLOUR_W-1){1'b0}}};
      end
`endif
      else begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end
    end
  end

  assign bus.vga_hsync    = hs_q;
  assign bus.vga_vsync    = vs_q;
  assign bus.R            = r_q;
  assign bus.G            = g_q;
  assign bus.B            = b_q;
  assign bus.capture_busy = busy_q;
  assign bus.trig_auto    = auto_q;

endmodule

// File: tb/tb_scope_trace_renderer.sv
// Randomised scoreboard bench for scope_trace_renderer on a reduced 22x11
// raster. Two renderers share the inputs: Y_SHIFT=7 and Y_SHIFT=6.
module tb_scope_trace_renderer;
  localparam int HT = 22, VT = 11, HA = 16, VA = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        sv;
  logic [19:0] sd;
  logic [9:0]  lvl;

  always #5 clock = ~clock;

  scope_trace_renderer_if #(.CHANNELS(2), .SAMPLE_W(10), .COLOUR_W(8)) bus_a ();
  scope_trace_renderer_if #(.CHANNELS(2), .SAMPLE_W(10), .COLOUR_W(8)) bus_b ();

  assign bus_a.sample_valid = sv;
  assign bus_a.sample_data  = sd;
  assign bus_a.trig_level   = lvl;
  assign bus_b.sample_valid = sv;
  assign bus_b.sample_data  = sd;
  assign bus_b.trig_level   = lvl;

  scope_trace_renderer #(
    .CHANNELS(2), .SAMPLE_W(10), .COLOUR_W(8),
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .Y_SHIFT(7), .AUTO_FRAMES(4)
  ) dut_a (.clock(clock), .reset(reset), .bus(bus_a));

  scope_trace_renderer #(
    .CHANNELS(2), .SAMPLE_W(10), .COLOUR_W(8),
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .Y_SHIFT(6), .AUTO_FRAMES(4)
  ) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        chk;
    logic [23:0] rgb_a;
    logic [23:0] rgb_b;
  } vid_t;

  typedef enum {M_WAIT_VB, M_ARMED, M_FILLING, M_FULL} mphase_t;

  vid_t        vq[$];
  logic [19:0] m_mem [HA];
  bit          m_ok  [HA];
  mphase_t     m_phase;
  bit          m_prev_ok, m_busy, m_auto;
  int          m_prev, m_frames, m_n, c;

  // Expected colour of pixel (h,v) from the captured column, {R,G,B}.
  function automatic logic [23:0] px(input int h, input int v, input int ysh);
    logic [23:0] col;
    int          y;
    col = 24'h0;
    for (int k = 1; k >= 0; k--) begin
      y = int'(m_mem[h][k*10 +: 10]) / (1 << ysh);
      if (y < VA && v == VA - 1 - y)
        col = (k == 0) ? 24'hFFFF00 : 24'h00FFFF;
    end
    return col;
  endfunction

  int   mh, mv, mcur;
  bit   mvb, mlevel, mdue;
  vid_t me;

  always @(posedge clock) begin
    if (reset) begin
      c = 0; m_phase = M_WAIT_VB; m_busy = 0; m_auto = 0;
      m_prev_ok = 0; m_frames = 0; m_n = 0;
      vq.delete();
    end else begin
      mh = c % HT;
      mv = (c / HT) % VT;
      me.hs  = (mh >= 18 && mh < 20);
      me.vs  = (mv == 9);
      me.chk = 1'b1;
      me.rgb_a = 24'h0;
      me.rgb_b = 24'h0;
      if (mh < HA && mv < VA) begin
        me.chk   = m_ok[mh];
        me.rgb_a = px(mh, mv, 7);
        me.rgb_b = px(mh, mv, 6);
      end
      vq.push_back(me);

      mvb  = (mh == 0 && mv == VA);
      mcur = int'(sd[9:0]);
      case (m_phase)
        M_WAIT_VB, M_FULL:
          if (mvb) begin m_phase = M_ARMED; m_prev_ok = 0; m_frames = 0; end
        M_ARMED: begin
          mlevel = m_prev_ok && (m_prev < int'(lvl)) && (mcur >= int'(lvl));
          mdue   = (m_frames >= 4);
          if (sv && (mlevel || mdue)) begin
            m_mem[0] = sd; m_ok[0] = 1; m_n = 1;
            m_auto = !mlevel; m_frames = 0; m_phase = M_FILLING;
          end else begin
            if (sv) begin m_prev = mcur; m_prev_ok = 1; end
            if (mvb) m_frames++;
          end
        end
        M_FILLING:
          if (sv) begin
            m_mem[m_n] = sd; m_ok[m_n] = 1; m_n++;
            if (m_n == HA) m_phase = M_FULL;
          end
        default: ;
      endcase
      m_busy = (m_phase == M_ARMED || m_phase == M_FILLING);
      c++;
    end
  end

  // ---------------- monitor ----------------
  vid_t mo;
  always @(negedge clock) begin
    if (!reset) begin
      check("busy_a", bus_a.capture_busy, m_busy);
      check("auto_a", bus_a.trig_auto, m_auto);
      check("busy_b", bus_b.capture_busy, m_busy);
      check("auto_b", bus_b.trig_auto, m_auto);
      if (vq.size() >= 2) begin
        mo = vq.pop_front();
        check("hsync", bus_a.vga_hsync, mo.hs);
        check("vsync", bus_a.vga_vsync, mo.vs);
        check("hsync_b", bus_b.vga_hsync, mo.hs);
        if (mo.chk) begin
          check("rgb_a", {bus_a.R, bus_a.G, bus_a.B}, mo.rgb_a);
          check("rgb_b", {bus_b.R, bus_b.G, bus_b.B}, mo.rgb_b);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic bit sig(input int which);
    case (which)
      0:       return bus_a.vga_hsync;
      1:       return bus_a.vga_vsync;
      default: return bus_a.capture_busy;
    endcase
  endfunction

  task automatic wait_for(input int which, input bit level, input int limit, input string name);
    int n;
    n = 0;
    while (sig(which) != level && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (n >= limit) begin
      n_vec++; n_bad++;
      $display("FAIL %s: no change after %0d cycles", name, limit);
    end
  endtask

  task automatic step(input bit v, input int a, input int b);
    sv = v;
    sd = {10'(b), 10'(a)};
    @(negedge clock);
  endtask

  function automatic int pick_ch1();
    case ($urandom_range(0, 2))
      0:       return 256;
      1:       return 1023;
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"}, bus_a.vga_hsync, 0);
    check({tag, "_vsync"}, bus_a.vga_vsync, 0);
    check({tag, "_rgb"}, {bus_a.R, bus_a.G, bus_a.B}, 0);
    check({tag, "_busy"}, bus_a.capture_busy, 0);
    check({tag, "_auto"}, bus_a.trig_auto, 0);
  endtask

  int t, n;
  bit v;

  initial begin
    sv = 0; sd = '0; lvl = 10'd512; reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b0;

    // raster timing
    wait_for(0, 1, 100, "hs_rise");
    check("hs_first", c, 20);
    t = c;
    wait_for(0, 0, 50, "hs_fall");
    check("hs_width", c - t, 2);
    wait_for(0, 1, 50, "hs_rise2");
    check("hs_period", c - t, 22);
    wait_for(1, 1, 300, "vs_rise");
    t = c;
    wait_for(1, 0, 300, "vs_fall");
    check("vs_width", c - t, 22);
    wait_for(1, 1, 300, "vs_rise2");
    check("vs_period", c - t, 242);

    // level trigger on a ramp, then fill with ch0=256
    check("armed_busy", bus_a.capture_busy, 1);
    for (int i = 0; i < 7; i++) step(1, i * 100, pick_ch1());
    n = 0;
    while (n < 15) begin
      v = ($urandom_range(0, 3) != 0);
      step(v, 256, pick_ch1());
      if (v) n++;
    end
    step(0, 0, 0);
    check("cap_done_busy", bus_a.capture_busy, 0);
    check("cap_level_auto", bus_a.trig_auto, 0);
    repeat (300) step(0, 0, 0);

    // auto trigger: ch0 never crosses the level
    wait_for(2, 1, 300, "rearm1");
    n = 0;
    while (bus_a.capture_busy && n < 2000) begin
      step(1, 0, int'($urandom_range(0, 1023)));
      n++;
    end
    if (n >= 2000) begin
      n_vec++; n_bad++;
      $display("FAIL auto_capture: busy still high after %0d cycles", n);
    end
    check("auto_flag", bus_a.trig_auto, 1);
    repeat (300) step(0, 0, 0);

    // reset in the middle of a capture (wr_addr = 7)
    wait_for(2, 1, 300, "rearm2");
    step(1, 0, pick_ch1());
    step(1, 600, pick_ch1());
    for (int i = 0; i < 6; i++) step(1, int'($urandom_range(0, 1023)), pick_ch1());
    check("midcap_busy", bus_a.capture_busy, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    sv = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    wait_for(2, 1, 400, "rearm_after_rst");
    check("rearm_cycle", c, 177);
    repeat (300) step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
